// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - matrix keypad scanner with frame debounce and press/release event FIFO
module keypad_scan_ctrl #(
  parameter  int ROWS       = 4,
  parameter  int COLS       = 4,
  parameter  int CLK_DIV    = 2500,
  parameter  int DEBOUNCE   = 3,
  parameter  int FIFO_DEPTH = 8,
  localparam int N          = ROWS * COLS,
  localparam int KW         = $clog2(N),
  localparam int EW         = KW + 1,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [COLS-1:0] col,
  output logic [ROWS-1:0] row,
  output logic [N-1:0]    key_state,
  output logic            evt_valid,
  output logic [EW-1:0]   evt_data,
  input  logic            evt_ready,
  output logic [CW-1:0]   evt_count,
  output logic            overflow,
  input  logic            ovf_clr
);

  localparam int SW = $clog2(CLK_DIV);
  localparam int RW = $clog2(ROWS);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, EMIT} emit_state_e;

  logic [COLS-1:0] col_s1_q, col_s2_q;
  logic [SW-1:0]   slot_q;
  logic [RW-1:0]   row_idx_q;
  logic [N-1:0]    raw_q, prev_q;
  logic [DW-1:0]   stable_q;
  logic            frame_end_q;
  logic            slot_end;

  assign slot_end = (slot_q == SW'(CLK_DIV - 1));
  assign row      = ~(ROWS'(1) << row_idx_q);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      col_s1_q    <= '1;
      col_s2_q    <= '1;
      slot_q      <= '0;
      row_idx_q   <= '0;
      raw_q       <= '0;
      frame_end_q <= 1'b0;
    end else begin
      col_s1_q    <= col;
      col_s2_q    <= col_s1_q;
      frame_end_q <= 1'b0;
      if (slot_end) begin
        slot_q <= '0;
        raw_q[int'(row_idx_q) * COLS +: COLS] <= ~col_s2_q;
        if (row_idx_q == RW'(ROWS - 1)) begin
          row_idx_q   <= '0;
          frame_end_q <= 1'b1;
        end else begin
          row_idx_q <= row_idx_q + RW'(1);
        end
      end else begin
        slot_q <= slot_q + SW'(1);
      end
    end
  end

  // Frame evaluation runs the cycle after the last row capture, while raw_q still holds the whole frame.
  logic [DW-1:0] stable_inc, stable_nx;
  logic          accept;

  assign stable_inc = (stable_q == DW'(DEBOUNCE)) ? stable_q : stable_q + DW'(1);
  assign stable_nx  = (raw_q == prev_q) ? stable_inc : DW'(1);
  assign accept     = frame_end_q && (stable_nx == DW'(DEBOUNCE)) && (raw_q != key_state);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      prev_q   <= '0;
      stable_q <= '0;
    end else if (frame_end_q) begin
      prev_q   <= raw_q;
      stable_q <= stable_nx;
    end
  end

  emit_state_e   state_q, state_d;
  logic [N-1:0]  key_state_q, key_state_d;
  logic [N-1:0]  diff_q, diff_d;
  logic [KW-1:0] low_idx;
  logic          push;
  logic [EW-1:0] push_data;

  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (diff_q[i]) low_idx = KW'(i);
    end
  end

  assign push_data = {key_state_q[low_idx], low_idx};

  always_comb begin
    state_d     = state_q;
    key_state_d = key_state_q;
    diff_d      = diff_q;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          key_state_d = raw_q;
          diff_d      = raw_q ^ key_state_q;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        push   = 1'b1;
        diff_d = diff_q & (diff_q - N'(1));
        if (diff_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      key_state_q <= '0;
      diff_q      <= '0;
    end else begin
      state_q     <= state_d;
      key_state_q <= key_state_d;
      diff_q      <= diff_d;
    end
  end

  assign key_state = key_state_q;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_q, rd_q;
  logic          full, pop, push_ok, ovf_q;

  assign evt_count = wr_q - rd_q;
  assign evt_valid = (wr_q != rd_q);
  assign full      = (evt_count == CW'(FIFO_DEPTH));
  assign pop       = evt_valid & evt_ready;
  // A pop in the same cycle frees the slot, so a push onto a full FIFO is still taken.
  assign push_ok   = push & (~full | pop);
  assign evt_data  = mem_q[rd_q[AW-1:0]];
  assign overflow  = ovf_q;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + (AW+1)'(1);
      if (pop)     rd_q <= rd_q + (AW+1)'(1);
      if (push && full && !pop) ovf_q <= 1'b1;
      else if (ovf_clr)         ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - self-checking bench for keypad_scan_ctrl against a keypad/event model
module tb_keypad_scan_ctrl;
  localparam int ROWS = 4, COLS = 4, CLK_DIV = 32, DEBOUNCE = 3, FIFO_DEPTH = 4;
  localparam int N = ROWS * COLS, KW = 4, EW = 5, CW = 3;
  localparam int FRAME  = ROWS * CLK_DIV;
  localparam int SETTLE = (DEBOUNCE + 2) * FRAME + 20;
  localparam int LAT_MAX = (DEBOUNCE + 1) * FRAME + 3;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [COLS-1:0] col;
  logic [ROWS-1:0] row;
  logic [N-1:0]    key_state;
  logic            evt_valid;
  logic [EW-1:0]   evt_data;
  logic            evt_ready = 1'b0;
  logic [CW-1:0]   evt_count;
  logic            overflow;
  logic            ovf_clr = 1'b0;

  logic [N-1:0]    keys = '0;
  logic [N-1:0]    model_ks = '0;
  logic [EW-1:0]   exp_q[$];
  logic [EW-1:0]   got_q[$];
  int              got_cyc[$];
  logic [EW-1:0]   mf_q[$];
  logic            ovf_m;
  int              n_pass = 0, n_total = 0;
  int              cyc = 0;

  keypad_scan_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn), .col(col), .row(row), .key_state(key_state),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
    .evt_count(evt_count), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Physical keypad: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!row[r] && keys[r*COLS + c]) col[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (rstn && evt_valid && evt_ready) begin
      got_q.push_back(evt_data);
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic gen_events(input logic [N-1:0] a, input logic [N-1:0] b);
    for (int i = 0; i < N; i++)
      if (a[i] != b[i]) exp_q.push_back({b[i], KW'(i)});
  endtask

  task automatic apply(input string tag, input logic [N-1:0] nk);
    gen_events(model_ks, nk);
    model_ks = nk;
    keys = nk;
    step(SETTLE);
    check({tag, "_ks"}, key_state, model_ks);
  endtask

  task automatic compare_events(input string tag);
    check({tag, "_nevt"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_evt%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic wait_ks_change(input string tag, output int n);
    logic [N-1:0] old;
    old = key_state;
    n = 0;
    while (key_state === old && n < SETTLE) begin
      step(1);
      n++;
    end
    check({tag, "_seen"}, key_state !== old, 1);
  endtask

  initial begin
    int n;
    logic [N-1:0] nk;
    logic [EW-1:0] ev;

    step(3);
    check("rst_row", row, 4'b1110);
    check("rst_ks", key_state, 0);
    check("rst_valid", evt_valid, 0);
    check("rst_count", evt_count, 0);
    check("rst_ovf", overflow, 0);

    rstn = 1'b1;
    step(CLK_DIV - 1);
    check("row_hold", row, 4'b1110);
    step(1);
    check("row_1", row, 4'b1101);
    step(CLK_DIV);
    check("row_2", row, 4'b1011);
    step(CLK_DIV);
    check("row_3", row, 4'b0111);
    step(CLK_DIV);
    check("row_wrap", row, 4'b1110);

    evt_ready = 1'b1;
    gen_events(model_ks, 16'h0040);
    model_ks = 16'h0040;
    keys = 16'h0040;
    wait_ks_change("k6_press", n);
    check("k6_latency_ok", n <= LAT_MAX, 1);
    check("k6_ks", key_state, 16'h0040);
    step(20);
    check("k6_evt_literal", got_q.size() > 0 ? got_q[0] : 5'h00, 5'h16);
    compare_events("k6_press");
    apply("k6_release", 16'h0000);
    check("k6_rel_literal", got_q.size() > 0 ? got_q[0] : 5'h1F, 5'h06);
    compare_events("k6_release");

    for (int k = 0; k < 5; k++) begin
      keys[6] = ~keys[6];
      step(FRAME);
      check($sformatf("bounce_ks%0d", k), key_state, 0);
    end
    keys = '0;
    step(SETTLE);
    check("bounce_final_ks", key_state, 0);
    compare_events("bounce");

    apply("k0_15", 16'h8001);
    check("k0_15_consec", got_cyc.size() >= 2 ? got_cyc[1] - got_cyc[0] : -1, 1);
    compare_events("k0_15");
    apply("k0_15_rel", 16'h0000);
    compare_events("k0_15_rel");

    for (int it = 0; it < 6; it++) begin
      nk = N'($urandom);
      apply($sformatf("rnd%0d", it), nk);
      compare_events($sformatf("rnd%0d", it));
    end
    apply("rnd_clear", 16'h0000);
    compare_events("rnd_clear");

    evt_ready = 1'b0;
    ovf_m = 1'b0;
    mf_q.delete();
    gen_events(model_ks, 16'h152A);
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      if (mf_q.size() < FIFO_DEPTH) mf_q.push_back(ev);
      else ovf_m = 1'b1;
    end
    model_ks = 16'h152A;
    keys = 16'h152A;
    step(SETTLE);
    check("ovf_ks", key_state, model_ks);
    check("ovf_count", evt_count, mf_q.size());
    check("ovf_flag", overflow, ovf_m);
    check("ovf_valid", evt_valid, 1);
    check("ovf_head", evt_data, mf_q[0]);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);

    gen_events(model_ks, 16'h1528);
    ev = exp_q.pop_front();
    model_ks = 16'h1528;
    keys = 16'h1528;
    wait_ks_change("pp", n);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    exp_q.push_back(mf_q.pop_front());
    mf_q.push_back(ev);
    check("pp_count", evt_count, FIFO_DEPTH);
    check("pp_ovf", overflow, 0);
    check("pp_head", evt_data, mf_q[0]);
    evt_ready = 1'b1;
    step(FIFO_DEPTH + 4);
    while (mf_q.size() > 0) exp_q.push_back(mf_q.pop_front());
    compare_events("drain");
    check("drain_count", evt_count, 0);
    apply("ovf_release", 16'h0000);
    compare_events("ovf_release");

    evt_ready = 1'b0;
    keys = 16'h00FF;
    wait_ks_change("mid", n);
    step(2);
    check("mid_count", evt_count, 2);
    rstn = 1'b0;
    step(1);
    check("mid_rst_count", evt_count, 0);
    check("mid_rst_valid", evt_valid, 0);
    check("mid_rst_ks", key_state, 0);
    check("mid_rst_row", row, 4'b1110);
    check("mid_rst_ovf", overflow, 0);
    keys = '0;
    model_ks = '0;
    rstn = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
